// File: rtl/alu_mult_seq.sv
// alu_mult_seq: sequential unsigned shift-add multiplier, one partial-product step per clock
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result_lo,
    output logic                 ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic             last;
    assign last = count == CW'(WIDTH - 1);
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : {WIDTH{1'b0}}};
    assign busy = state == RUN;
    assign done = state == DONE;
    assign product = acc;
    assign result_lo = acc[WIDTH-1:0];
    assign ovf = |acc[2*WIDTH-1:WIDTH];
    // next state: IDLE waits for start, RUN counts WIDTH steps, DONE lasts one cycle
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) : IDLE;
    end
    // state register; reset wins over any pending start
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // datapath: load operands on accept, then add-and-shift keeping the carry in the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (state == IDLE && start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            count <= '0;
        end else if (state == RUN) begin
            acc   <= {sum, acc[WIDTH-1:1]};
            count <= count + CW'(1);
        end
    end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: randomized self-checking bench against an arithmetic product model
module tb_alu_mult_seq;
    localparam int W = 32;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, ovf;
    logic [2*W-1:0] product;
    logic [W-1:0]   result_lo;
    int             total = 0;
    int             passed = 0;

    alu_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .result_lo(result_lo), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // count edges until done is seen (bounded), plus busy samples and overlap
    task automatic wait_done(output int n, output int bn, output int both);
        n = 0;
        bn = 0;
        both = 0;
        do begin
            step();
            n++;
            if (busy) bn++;
            if (busy && done) both++;
        end while (!done && n < 100);
    endtask

    // one full multiply; noisy mode re-pulses start with new operands in RUN and DONE
    task automatic mul(input logic [W-1:0] x, input logic [W-1:0] y, input bit noisy, input bit full);
        logic [63:0] exp;
        int n, bn, both, extra;
        exp = 64'(x) * 64'(y);
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        bn = busy ? 1 : 0;
        n = 0;
        both = 0;
        do begin
            step();
            start = 1'b0;
            n++;
            if (busy) bn++;
            if (busy && done) both++;
            if (noisy && (n == 5 || n == 20)) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end
        end while (!done && n < 100);
        chk("product", product, exp);
        if (full) begin
            chk("latency", 64'(n + 1), 64'd33);
            chk("busy_cycles", 64'(bn), 64'd32);
            chk("busy_done_excl", 64'(both), 64'd0);
            chk("result_lo", 64'(result_lo), 64'(exp[W-1:0]));
            chk("ovf", 64'(ovf), 64'(exp[63:32] != 0));
        end
        if (noisy) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            step();
            start = 1'b0;
            extra = 0;
            repeat (4) begin
                if (done || busy) extra++;
                step();
            end
            chk("noisy_single_done", 64'(extra), 64'd0);
            chk("noisy_product_held", product, exp);
        end else begin
            step();
        end
    endtask

    initial begin
        int n, bn, both;
        logic [W-1:0] x, y;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_result_lo", 64'(result_lo), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        step();

        mul(32'd3, 32'd5, 1'b0, 1'b1);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        mul(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        mul(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
        chk("held_after_done", product, 64'h1_0000_0000);
        mul(32'd123457, 32'd98765, 1'b1, 1'b1);

        // reset in the middle of RUN
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_product", product, 64'd0);
        step();
        chk("midrst_stays_idle", 64'(busy), 64'd0);
        mul(32'd7, 32'd9, 1'b0, 1'b1);

        // reset together with start: start is lost
        rst_n = 1'b0;
        start = 1'b1;
        a = 32'd11;
        b = 32'd13;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        step();
        chk("rst_start_idle", 64'(busy), 64'd0);

        // back-to-back with start held high
        a = 32'd6;
        b = 32'd7;
        start = 1'b1;
        step();
        chk("b2b_first_accept", 64'(busy), 64'd1);
        wait_done(n, bn, both);
        chk("b2b_prod0", product, 64'd42);
        a = 32'd100000;
        b = 32'd100000;
        wait_done(n, bn, both);
        chk("b2b_spacing", 64'(n), 64'd34);
        chk("b2b_prod1", product, 64'd10000000000);
        chk("b2b_ovf1", 64'(ovf), 64'd1);
        chk("b2b_excl", 64'(both), 64'd0);
        start = 1'b0;
        step();
        step();

        // random vectors against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 10 == 0) x = x >> $urandom_range(31, 0);
            mul(x, y, 1'b0, i < 20);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
